// File: rtl/vga_vram_arbiter.sv
// Shares one single-port VRAM between CPU MMIO accesses and VGA scan-out.
// Each source row is burst into a ping-pong line buffer; the CPU gets the remaining VRAM cycles.
module vga_vram_arbiter #(
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int AW          = 17,
    parameter int FIRST_FETCH = 29,
    parameter int H_OFF       = 48
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [9:0]    h_addr,
    input  logic [9:0]    v_addr,
    output logic [11:0]   vga_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [11:0]   cpu_wdata,
    output logic          cpu_ready,
    output logic [11:0]   cpu_rdata,
    output logic          cpu_rvalid,
    output logic          vram_en,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [11:0]   vram_wdata,
    input  logic [11:0]   vram_rdata
);

    localparam int XW = $clog2(FB_W);
    localparam logic [AW-1:0] NPIX   = AW'(FB_W * FB_H);
    localparam logic [9:0]    LC_F0  = 10'(FIRST_FETCH);
    localparam logic [9:0]    LC_F1  = 10'(FIRST_FETCH + 2 * (FB_H - 1));
    localparam logic [9:0]    LC_D0  = 10'(FIRST_FETCH + 1);
    localparam logic [9:0]    LC_D1  = 10'(FIRST_FETCH + 2 * FB_H);
    localparam logic [9:0]    HC_D0  = 10'(H_OFF);
    localparam logic [9:0]    HC_D1  = 10'(H_OFF + 639);
    localparam logic [XW-1:0] X_LAST = XW'(FB_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_CPU, SRC_ZERO} src_t;

    state_t        state, state_nxt;
    src_t          rd_src, rd_nxt;
    logic [9:0]    lc, hcnt, lc_nxt, row_diff;
    logic [AW-1:0] faddr;
    logic [XW-1:0] fidx, fidx_d;
    logic          dst, hsync_d, vsync_d;
    logic          line_ev, frame_ev, fetch_hit, cpu_oor;
    logic [8:0]    px;
    logic          in_win;
    logic [11:0]   lbuf0 [FB_W];
    logic [11:0]   lbuf1 [FB_W];
    logic          unused_bits;

    assign line_ev   = hsync & ~hsync_d;
    assign frame_ev  = vsync & ~vsync_d;
    assign lc_nxt    = lc + 10'd1;
    assign row_diff  = lc_nxt - LC_F0;
    assign fetch_hit = line_ev & ~frame_ev & lc_nxt[0] & (lc_nxt >= LC_F0) & (lc_nxt <= LC_F1);
    assign cpu_oor   = cpu_addr >= NPIX;

    always_comb begin
        state_nxt  = state;
        rd_nxt     = SRC_NONE;
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        cpu_ready  = 1'b0;
        case (state)
            FETCH: begin
                vram_en   = 1'b1;
                vram_addr = faddr;
                rd_nxt    = SRC_FETCH;
                if (fidx == X_LAST) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Fetch owns the port; CPU only rides the idle and drain cycles.
        if (state != FETCH && cpu_req) begin
            cpu_ready  = 1'b1;
            vram_en    = ~cpu_oor;
            vram_we    = cpu_we & ~cpu_oor;
            vram_addr  = cpu_addr;
            vram_wdata = cpu_wdata;
            rd_nxt     = cpu_we ? SRC_NONE : (cpu_oor ? SRC_ZERO : SRC_CPU);
        end
        if (frame_ev) begin
            state_nxt = IDLE;
            if (rd_nxt == SRC_FETCH) rd_nxt = SRC_NONE;
        end else if (fetch_hit) begin
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rd_src  <= SRC_NONE;
            lc      <= '0;
            hcnt    <= '0;
            faddr   <= '0;
            fidx    <= '0;
            fidx_d  <= '0;
            dst     <= 1'b0;
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_src  <= rd_nxt;
            hsync_d <= hsync;
            vsync_d <= vsync;
            fidx_d  <= fidx;
            if (frame_ev) begin
                lc <= '0;
                if (hcnt != 10'h3FF) hcnt <= hcnt + 10'd1;
            end else if (line_ev) begin
                lc   <= lc_nxt;
                hcnt <= 10'd1;
            end else if (hcnt != 10'h3FF) begin
                hcnt <= hcnt + 10'd1;
            end
            if (frame_ev)            faddr <= '0;
            else if (state == FETCH) faddr <= faddr + AW'(1);
            if (fetch_hit) begin
                fidx <= '0;
                dst  <= row_diff[1];
            end else if (state == FETCH) begin
                fidx <= fidx + XW'(1);
            end
        end
    end

    // Write lands one cycle after the read was issued, at the index it was issued for.
    always_ff @(posedge pclk) begin
        if (rd_src == SRC_FETCH) begin
            if (dst) lbuf1[fidx_d] <= vram_rdata;
            else     lbuf0[fidx_d] <= vram_rdata;
        end
    end

    assign cpu_rvalid = (rd_src == SRC_CPU) || (rd_src == SRC_ZERO);
    assign cpu_rdata  = (rd_src == SRC_CPU) ? vram_rdata : 12'd0;

    assign px     = h_addr[9:1];
    assign in_win = (lc >= LC_D0) && (lc <= LC_D1) && (hcnt >= HC_D0) && (hcnt <= HC_D1)
                    && (px < 9'(FB_W));
    assign vga_data = !in_win ? 12'd0 : (v_addr[1] ? lbuf1[px] : lbuf0[px]);

    assign unused_bits = ^{v_addr[9:2], v_addr[0], h_addr[0], row_diff[9:2], row_diff[0]};

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: bench-driven sync timing with a behavioural VRAM.
module tb_vga_vram_arbiter;

    logic        pclk = 1'b0;
    logic        reset_n, hsync, vsync;
    logic [9:0]  h_addr, v_addr;
    logic [11:0] vga_data;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [11:0] cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_rvalid;
    logic        vram_en, vram_we;
    logic [16:0] vram_addr;
    logic [11:0] vram_wdata, vram_rdata;

    int checks = 0;
    int failures = 0;
    int errs;

    logic [11:0] mem [0:131071];

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            vram_rdata <= mem[vram_addr];
        end
    end

    vga_vram_arbiter dut (
        .pclk(pclk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic vpulse();
        tick(); vsync = 1'b1;
        tick(); vsync = 1'b0;
    endtask

    task automatic hline(input int len);
        tick(); hsync = 1'b1;
        tick(); hsync = 1'b0;
        repeat (len - 2) tick();
    endtask

    // Leaves the bench at the first negedge after the line event.
    task automatic hstart();
        tick(); hsync = 1'b1;
        tick(); hsync = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) mem[a] = a[11:0];
        reset_n = 1'b0; hsync = 1'b0; vsync = 1'b0;
        h_addr = '0; v_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        chk("rst_vram_en", vram_en, 0);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vga_data", vga_data, 0);
        repeat (3) tick();
        reset_n = 1'b1;

        // Frame, then lines up to lc=28; lc=29 fetches row 0 while a CPU write waits.
        vpulse();
        repeat (28) hline(4);
        hstart();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd100; cpu_wdata = 12'hABC;
        errs = 0;
        for (int i = 0; i < 320; i++) begin
            #1;
            if (!(vram_en === 1'b1 && vram_we === 1'b0 && vram_addr === 17'(i)
                  && cpu_ready === 1'b0 && vga_data === 12'd0)) errs++;
            tick();
        end
        chk("fetch_row0_seq", errs, 0);
        #1;
        chk("drain_wr_ready", cpu_ready, 1);
        chk("drain_wr_en", vram_en, 1);
        chk("drain_wr_we", vram_we, 1);
        chk("drain_wr_addr", vram_addr, 100);
        chk("drain_wr_data", vram_wdata, 12'hABC);
        tick(); cpu_we = 1'b0;
        #1;
        chk("rd_grant_ready", cpu_ready, 1);
        chk("rd_grant_en_we", {vram_en, vram_we}, 2'b10);
        chk("rd_grant_no_rvalid", cpu_rvalid, 0);
        tick(); cpu_req = 1'b0;
        #1;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 12'hABC);
        chk("rd_ready_low", cpu_ready, 0);
        tick(); cpu_req = 1'b1; cpu_addr = 17'd76800;
        #1;
        chk("oor_ready", cpu_ready, 1);
        chk("oor_vram_en", vram_en, 0);
        tick(); cpu_req = 1'b0;
        #1;
        chk("oor_rvalid", cpu_rvalid, 1);
        chk("oor_rdata", cpu_rdata, 0);
        tick();
        #1;
        chk("rvalid_single", cpu_rvalid, 0);

        // lc=30 plain line, lc=31 fetches row 1 from 320..639.
        hline(400);
        hstart();
        errs = 0;
        for (int i = 0; i < 320; i++) begin
            #1;
            if (!(vram_en === 1'b1 && vram_addr === 17'(320 + i))) errs++;
            tick();
        end
        chk("fetch_row1_seq", errs, 0);
        #1;
        chk("row1_drain_idle_port", vram_en, 0);
        tick();
        #1;
        chk("row1_after_drain", vram_en, 0);

        // lc=32..39, then lc=40 shows source row 5 (v_addr=10) from buffer 1.
        repeat (8) hline(400);
        hstart();
        v_addr = 10'd10;
        for (int hc = 1; hc <= 700; hc++) begin
            h_addr = (hc >= 100) ? 10'd0 : 10'd7;
            #1;
            if (hc == 47)  chk("hblank_before", vga_data, 0);
            if (hc == 55)  chk("pix_r5_c3", vga_data, 12'h643);
            if (hc == 110) chk("pix_r5_c0", vga_data, 12'h640);
            if (hc == 688) chk("hblank_after", vga_data, 0);
            tick();
        end

        // lc=41 fetches row 6; reset lands at fidx=100.
        hstart();
        repeat (100) tick();
        #1;
        chk("row6_fidx100_addr", vram_addr, 2020);
        reset_n = 1'b0;
        #1;
        chk("midrst_vram_en", vram_en, 0);
        chk("midrst_cpu_ready", cpu_ready, 0);
        chk("midrst_vga_data", vga_data, 0);
        tick(); reset_n = 1'b1;
        #1;
        chk("postrst_vram_en", vram_en, 0);
        vpulse();
        repeat (28) hline(4);
        hstart();
        #1;
        chk("postrst_fetch_en", vram_en, 1);
        chk("postrst_fetch_addr", vram_addr, 0);
        repeat (9) tick();
        #1;
        chk("postrst_fetch_addr9", vram_addr, 9);

        // Frame event mid-fetch aborts to IDLE, CPU is served at once.
        tick(); vsync = 1'b1;
        tick(); vsync = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd5;
        #1;
        chk("abort_cpu_ready", cpu_ready, 1);
        chk("abort_vram_addr", vram_addr, 5);
        tick(); cpu_req = 1'b0;
        #1;
        chk("abort_rd_rvalid", cpu_rvalid, 1);
        chk("abort_rd_rdata", cpu_rdata, 5);
        tick();
        #1;
        chk("abort_idle_port", vram_en, 0);
        repeat (28) hline(4);
        hstart();
        #1;
        chk("abort_refetch_en", vram_en, 1);
        chk("abort_refetch_addr", vram_addr, 0);
        tick();
        #1;
        chk("abort_refetch_addr1", vram_addr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port VRAM between the pipelined RV32I CPU (MMIO path) and the VGA scan-out.
- Framebuffer is 320x240 words of 12-bit RGB444, shown 2x-scaled on the 640x480 vga_driver timing.
- Once per source row, it bursts that row from VRAM into a ping-pong line buffer. The CPU gets every VRAM cycle the burst does not use.
- vga_data is produced from the line buffer, indexed by the driver's h_addr/v_addr, and blanked outside the active window.

Parameters:
- FB_W, 320, source pixels per row
- FB_H, 240, source rows
- AW, 17, VRAM word-address width
- FIRST_FETCH, 29, line-event count at which row 0 is fetched
- H_OFF, 48, hcnt value of the first active pixel

Ports:
- pclk  in  1  25 MHz pixel clock
- reset_n  in  1  asynchronous active-low reset
- hsync  in  1  from vga_driver
- vsync  in  1  from vga_driver
- h_addr  in  10  from vga_driver
- v_addr  in  10  from vga_driver
- vga_data  out  12  pixel colour to vga_driver
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1 = write
- cpu_addr  in  AW  word address
- cpu_wdata  in  12  write data
- cpu_ready  out  1  grant pulse; access taken this cycle
- cpu_rdata  out  12  read data
- cpu_rvalid  out  1  read data valid
- vram_en  out  1  VRAM access enable
- vram_we  out  1  VRAM write enable
- vram_addr  out  AW  VRAM address
- vram_wdata  out  12  VRAM write data
- vram_rdata  in  12  VRAM read data; 1-cycle read latency

Behaviour:
- Reset (async, reset_n=0): all of the following are cleared, and all outputs are 0:
  - state=IDLE, lc=0, hcnt=0, faddr=0, fidx=0
  - hsync_d=0, vsync_d=0, rd_src=NONE
  - line buffers are not cleared
- Events (hsync_d/vsync_d are registered copies of the sync inputs):
  - line event = hsync & ~hsync_d.
  - frame event = vsync & ~vsync_d.
- Counters:
  - Frame event: lc<=0, faddr<=0. If state!=IDLE, abort to IDLE and do not write the line buffer in the next cycle.
  - Otherwise a line event sets lc<=lc+1, and hcnt<=1.
  - Otherwise hcnt<=hcnt+1, saturating at 1023.
- Fetch trigger: on a line event where the new lc is odd and FIRST_FETCH <= lc <= FIRST_FETCH+2*(FB_H-1):
  - row r = (lc-FIRST_FETCH)/2.
  - state<=FETCH, fidx<=0, dst buffer <= r&1.
- FETCH state, each cycle:
  - Drive vram_en=1, vram_we=0, vram_addr=faddr; then faddr+1, fidx+1.
  - When fidx reaches FB_W-1, go to DRAIN.
- DRAIN: one cycle; captures the last read, then IDLE.
- Read pipeline: rd_src records who issued each read. The cycle after a FETCH read, vram_rdata is written to lbuf[dst][fidx_d].
- CPU arbitration:
  - The fetch has absolute priority. CPU is granted only when state is IDLE or DRAIN; worst-case CPU wait is FB_W cycles.
  - Grant cycle: cpu_ready=1, vram_en=1, vram_we=cpu_we, vram_addr=cpu_addr, vram_wdata=cpu_wdata.
  - CPU read: the next cycle gives cpu_rvalid=1 and cpu_rdata=vram_rdata.
  - At most one grant per cycle; back-to-back grants are allowed.
- Out-of-range CPU address (cpu_addr >= FB_W*FB_H):
  - Granted with no VRAM access (vram_en=0).
  - A read returns cpu_rvalid=1 next cycle with cpu_rdata=0.
- Display output:
  - vga_data = lbuf[v_addr[1]][h_addr>>1], combinational.
  - Forced to 0 unless FIRST_FETCH+1 <= lc <= FIRST_FETCH+2*FB_H and H_OFF <= hcnt <= H_OFF+639.
- Ping-pong: row r+1 is fetched during the second display line of row r, into the buffer not being shown.
- Write/display collision on the same buffer cannot occur by construction.

Test Plan:
- Reset mid-FETCH (fidx=100) -> next cycle: vram_en=0, cpu_ready=0, vga_data=0; with frame timing running, the next fetch starts at faddr=0.
- Full frame with vga_driver; VRAM preloaded with mem[a]=a[11:0] -> at v_addr=10, h_addr=7, vga_data=(5*320+3)&0xFFF=0x643. During blanking, vga_data=0.
- cpu_req write to addr 100, data 0xABC, issued during FETCH -> cpu_ready held 0 until DRAIN/IDLE, then one pulse with vram_we=1, vram_addr=100. A following read of addr 100 gives cpu_rvalid one cycle after grant with 0xABC.
- Line event with lc=29 -> exactly 320 consecutive reads at addresses 0..319, then one DRAIN cycle; next fetch (lc=31) reads 320..639.
- CPU read of addr 76800 -> cpu_ready=1, vram_en=0, next cycle cpu_rvalid=1, cpu_rdata=0.
- Frame event forced during FETCH -> state IDLE next cycle, no line-buffer write, faddr=0.
